matrix_unloader: RTL and testbench

MATRIX_UNLOADER -- requirements
Module: matrix_unloader

---
 rtl/matrix_unloader.sv | 126 ++++++++++++
 tb/tb_matrix_unloader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/matrix_unloader.sv
// rtl/matrix_unloader.sv - captures a flattened n x p float matrix and streams it out element by element
// Handshakes: c_stb/c_ack on the capture side, z_stb/z_ack per element on the output side.

module matrix_unloader #(
   parameter int n = 2,
   parameter int p = 2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [0:32*n*p-1]                   matrix_C,
   input  logic                                c_stb,
   output logic                                c_ack,
   output logic [31:0]                         z,
   output logic                                z_stb,
   input  logic                                z_ack,
   output logic [((n > 1) ? $clog2(n) : 1)-1:0] z_row,
   output logic [((p > 1) ? $clog2(p) : 1)-1:0] z_col,
   output logic                                z_last,
   output logic                                busy
);

   localparam int NE = n * p;
   localparam int KW = (NE > 1) ? $clog2(NE) : 1;
   localparam int RW = (n > 1) ? $clog2(n) : 1;
   localparam int CW = (p > 1) ? $clog2(p) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NE - 1);
   localparam logic [CW-1:0] C_LAST = CW'(p - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACK, S_SEND} state_t;

   state_t         state_q;
   logic [KW-1:0]  k_q;
   logic [KW-1:0]  k_d;
   logic           armed_q;
   logic           c_ack_q;
   logic           z_stb_q;
   logic [31:0]    z_q;
   logic [RW-1:0]  row_q;
   logic [CW-1:0]  col_q;
   logic           z_last_q;
   logic [31:0]    mem_q [NE];
   logic           capture;

   assign capture = (state_q == S_IDLE) && c_stb && armed_q;
   assign k_d     = k_q + KW'(1);

   // Buffer is only ever read after a capture, so it needs no reset.
   always_ff @(posedge clk) begin
      if (capture) begin
         for (int i = 0; i < NE; i++) begin
            mem_q[i] <= matrix_C[i*32 +: 32];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         k_q      <= '0;
         armed_q  <= 1'b1;
         c_ack_q  <= 1'b0;
         z_stb_q  <= 1'b0;
         z_q      <= '0;
         row_q    <= '0;
         col_q    <= '0;
         z_last_q <= 1'b0;
      end else begin
         // A low strobe re-arms capture in any state; capture requires a high strobe.
         if (!c_stb) begin
            armed_q <= 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (capture) begin
                  armed_q <= 1'b0;
                  c_ack_q <= 1'b1;
                  state_q <= S_ACK;
               end
            end
            S_ACK: begin
               c_ack_q  <= 1'b0;
               k_q      <= '0;
               row_q    <= '0;
               col_q    <= '0;
               z_q      <= mem_q[0];
               z_last_q <= (K_LAST == '0);
               z_stb_q  <= 1'b1;
               state_q  <= S_SEND;
            end
            S_SEND: begin
               if (z_ack) begin
                  if (k_q == K_LAST) begin
                     state_q  <= S_IDLE;
                     z_stb_q  <= 1'b0;
                     z_q      <= '0;
                     z_last_q <= 1'b0;
                     k_q      <= '0;
                     row_q    <= '0;
                     col_q    <= '0;
                  end else begin
                     k_q      <= k_d;
                     z_q      <= mem_q[k_d];
                     z_last_q <= (k_d == K_LAST);
                     if (col_q == C_LAST) begin
                        col_q <= '0;
                        row_q <= row_q + RW'(1);
                     end else begin
                        col_q <= col_q + CW'(1);
                     end
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign c_ack  = c_ack_q;
   assign z      = z_q;
   assign z_stb  = z_stb_q;
   assign z_row  = row_q;
   assign z_col  = col_q;
   assign z_last = z_last_q;
   assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_matrix_unloader.sv
// tb/tb_matrix_unloader.sv - randomized self-checking bench for matrix_unloader
// Expected element order comes from the matrix itself: word k, row k/2, col k%2, last at k==3.

module tb_matrix_unloader;

   logic         clk = 1'b0;
   logic         rst;
   logic [0:127] matrix_C;
   logic         c_stb;
   logic         c_ack;
   logic [31:0]  z;
   logic         z_stb;
   logic         z_ack;
   logic [0:0]   z_row;
   logic [0:0]   z_col;
   logic         z_last;
   logic         busy;

   logic [0:31]  m1;
   logic         stb1;
   logic         c_ack1;
   logic [31:0]  z1;
   logic         z_stb1;
   logic         ack1;
   logic [0:0]   row1;
   logic [0:0]   col1;
   logic         last1;
   logic         busy1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   matrix_unloader #(.n(2), .p(2)) dut (
      .clk(clk), .rst(rst), .matrix_C(matrix_C), .c_stb(c_stb), .c_ack(c_ack),
      .z(z), .z_stb(z_stb), .z_ack(z_ack), .z_row(z_row), .z_col(z_col),
      .z_last(z_last), .busy(busy)
   );

   matrix_unloader #(.n(1), .p(1)) dut1 (
      .clk(clk), .rst(rst), .matrix_C(m1), .c_stb(stb1), .c_ack(c_ack1),
      .z(z1), .z_stb(z_stb1), .z_ack(ack1), .z_row(row1), .z_col(col1),
      .z_last(last1), .busy(busy1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_z_stb"}, z_stb, 0);
      check({tag, "_z"}, z, 0);
      check({tag, "_z_row"}, z_row, 0);
      check({tag, "_z_col"}, z_col, 0);
      check({tag, "_z_last"}, z_last, 0);
      check({tag, "_c_ack"}, c_ack, 0);
   endtask

   // mode 0: z_ack always high, 1: toggling starting low, 2: random
   task automatic unload(input logic [0:127] mat, input int mode, input bit hold, input bit chg);
      logic [31:0] exp_q[$];
      int          idx;
      int          cyc;
      bit          ph;
      bit          a;
      exp_q = {};
      for (int k = 0; k < 4; k++) exp_q.push_back(mat[k*32 +: 32]);
      matrix_C = mat;
      c_stb    = 1'b1;
      z_ack    = 1'b0;
      step();
      check("c_ack_on", c_ack, 1);
      check("busy_ack", busy, 1);
      check("z_stb_ack", z_stb, 0);
      if (!hold) c_stb = 1'b0;
      if (chg) matrix_C = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
      step();
      idx = 0;
      cyc = 0;
      ph  = 1'b0;
      while (idx < 4 && cyc < 64) begin
         a  = (mode == 0) ? 1'b1 : (mode == 1) ? ph : 1'($urandom_range(0, 1));
         ph = ~ph;
         z_ack = a;
         check("c_ack_send", c_ack, 0);
         check("z_stb", z_stb, 1);
         check("z", z, exp_q[idx]);
         check("z_row", z_row, idx / 2);
         check("z_col", z_col, idx % 2);
         check("z_last", z_last, (idx == 3) ? 1 : 0);
         step();
         if (a) idx++;
         cyc++;
      end
      z_ack = 1'b0;
      check("unload_done", idx, 4);
      check("z_stb_end", z_stb, 0);
      check("busy_end", busy, 0);
      if (mode == 0) check("send_cycles", cyc, 4);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [0:127] a_mat;
      logic [0:127] r_mat;
      a_mat = {32'h40E00000, 32'h41200000, 32'h41700000, 32'h41E00000};
      rst = 1'b0; c_stb = 1'b0; z_ack = 1'b0; matrix_C = '0;
      stb1 = 1'b0; ack1 = 1'b0; m1 = '0;
      step();
      step();
      check_idle_zero("reset");
      check("reset_busy1", busy1, 0);
      @(negedge clk) rst = 1'b1;
      step();

      // 1x1 matrix
      m1 = 32'h3F800000; stb1 = 1'b1;
      step();
      check("one_c_ack", c_ack1, 1);
      stb1 = 1'b0; ack1 = 1'b1;
      step();
      check("one_z_stb", z_stb1, 1);
      check("one_z", z1, 32'h3F800000);
      check("one_last", last1, 1);
      check("one_row", row1, 0);
      check("one_col", col1, 0);
      step();
      ack1 = 1'b0;
      check("one_busy_end", busy1, 0);
      check("one_z_stb_end", z_stb1, 0);

      unload(a_mat, 0, 0, 0);
      step();
      unload(a_mat, 1, 0, 0);
      step();

      // strobe held through the whole unload: no recapture until it drops
      unload(a_mat, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("no_recapture_busy", busy, 0);
         check("no_recapture_ack", c_ack, 0);
      end
      c_stb = 1'b0;
      step();

      unload(a_mat, 2, 0, 1);
      step();

      // reset after the second transfer, strobe still high on release
      matrix_C = a_mat; c_stb = 1'b1; z_ack = 1'b1;
      step();
      check("rst_pre_c_ack", c_ack, 1);
      step();
      check("rst_pre_z0", z, 32'h40E00000);
      step();
      check("rst_pre_z1", z, 32'h41200000);
      step();
      check("rst_pre_z2", z, 32'h41700000);
      rst = 1'b0;
      z_ack = 1'b0;
      #1;
      check_idle_zero("async_rst");
      step();
      check_idle_zero("rst_held");
      @(negedge clk) rst = 1'b1;
      unload(a_mat, 0, 1, 0);
      c_stb = 1'b0;
      step();

      for (int it = 0; it < 6; it++) begin
         for (int k = 0; k < 4; k++) r_mat[k*32 +: 32] = $urandom;
         repeat ($urandom_range(0, 3)) step();
         unload(r_mat, 2, 0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
